axi4_lite_master_bridge: RTL and testbench

Converts the CPU's single-outstanding load/store request port into AXI4-Lite master transactions. It drives the unified master side of the AXI4-Lite interconnect, directly upstream of the address decoder and slave routing. It adds a response timeout, so an access to an unmapped address completes with an error instead of hanging the core.

---
 rtl/axi4_lite_master_bridge_if.sv | 41 ++++
 rtl/axi4_lite_master_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_axi4_lite_master_bridge.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_master_bridge_if.sv
// ----------------------------------------------------------------------------
// axi4_lite_if
// AXI4-Lite signal bundle shared by a master (the CPU bridge) and the
// interconnect / slave side.
//   master modport : drives AW*, W*, BREADY, AR*, RREADY
//   slave  modport : drives AWREADY, WREADY, B*, ARREADY, R*
// ----------------------------------------------------------------------------
interface axi4_lite_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   AWADDR;
   logic                    AWVALID;
   logic                    AWREADY;
   logic [DATA_WIDTH-1:0]   WDATA;
   logic [DATA_WIDTH/8-1:0] WSTRB;
   logic                    WVALID;
   logic                    WREADY;
   logic [1:0]              BRESP;
   logic                    BVALID;
   logic                    BREADY;
   logic [ADDR_WIDTH-1:0]   ARADDR;
   logic                    ARVALID;
   logic                    ARREADY;
   logic [DATA_WIDTH-1:0]   RDATA;
   logic [1:0]              RRESP;
   logic                    RVALID;
   logic                    RREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/axi4_lite_master_bridge.sv
// ----------------------------------------------------------------------------
// axi4_lite_master_bridge
// Turns the CPU's single-outstanding load/store port into AXI4-Lite master
// transactions, with a response timeout so an unmapped access completes with
// an error (mem_resp = 2'b11) instead of hanging the core.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   mem_req    request valid (level, only looked at in IDLE)
//   mem_we     1 = store, 0 = load
//   mem_addr   byte address, passed through unmodified to AW/ARADDR
//   mem_wdata  store data
//   mem_wstrb  store byte enables
//   mem_done   one-cycle completion pulse
//   mem_rdata  load data, held until the next load completes
//   mem_resp   AXI response of the completed access, 2'b11 on timeout
//   master_if  AXI4-Lite master side
// ----------------------------------------------------------------------------
module axi4_lite_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_req,
   input  logic                    mem_we,
   input  logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
   output logic                    mem_done,
   output logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic [1:0]              mem_resp,
   axi4_lite_if.master             master_if
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      WRESP = 3'd2,
      RADDR = 3'd3,
      RDATA = 3'd4,
      RESP  = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_nxt;

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_W-1:0]     r_wstrb;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_resp;
   logic                  r_done;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_aw_ok;
   logic                  r_w_ok;
   logic [CNT_W-1:0]      r_cnt;

   logic                  w_aw_ok_nxt;
   logic                  w_w_ok_nxt;
   logic                  w_accept;
   logic                  w_tmo;
   logic                  w_tmo_fire;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_active;

   assign w_aw_hs  = r_awvalid & master_if.AWREADY;
   assign w_w_hs   = r_wvalid  & master_if.WREADY;
   assign w_active = (r_state == WRITE) || (r_state == WRESP) ||
                     (r_state == RADDR) || (r_state == RDATA);
   // Counter value TMO_LAST is reached in the TIMEOUT_CYCLES-th cycle after
   // acceptance; that cycle is the last chance for a real completion.
   assign w_tmo    = (TIMEOUT_CYCLES != 0) && (r_cnt == TMO_LAST);

   // ------------------------------------------------------------------------
   // Next-state logic. Completion is checked before the timeout in every
   // state so a handshake in the final cycle still wins.
   // ------------------------------------------------------------------------
   always_comb begin
      w_nxt       = r_state;
      w_aw_ok_nxt = r_aw_ok;
      w_w_ok_nxt  = r_w_ok;
      w_accept    = 1'b0;
      w_tmo_fire  = 1'b0;
      case (r_state)
         IDLE: begin
            if (mem_req) begin
               w_accept    = 1'b1;
               w_aw_ok_nxt = 1'b0;
               w_w_ok_nxt  = 1'b0;
               w_nxt       = mem_we ? WRITE : RADDR;
            end
         end
         WRITE: begin
            w_aw_ok_nxt = r_aw_ok | w_aw_hs;
            w_w_ok_nxt  = r_w_ok  | w_w_hs;
            if (w_aw_ok_nxt && w_w_ok_nxt) begin
               w_nxt = WRESP;
            end else if (w_tmo) begin
               w_tmo_fire = 1'b1;
               w_nxt      = RESP;
            end
         end
         WRESP: begin
            if (master_if.BVALID) begin
               w_nxt = RESP;
            end else if (w_tmo) begin
               w_tmo_fire = 1'b1;
               w_nxt      = RESP;
            end
         end
         RADDR: begin
            if (master_if.ARREADY) begin
               w_nxt = RDATA;
            end else if (w_tmo) begin
               w_tmo_fire = 1'b1;
               w_nxt      = RESP;
            end
         end
         RDATA: begin
            if (master_if.RVALID) begin
               w_nxt = RESP;
            end else if (w_tmo) begin
               w_tmo_fire = 1'b1;
               w_nxt      = RESP;
            end
         end
         RESP:    w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_nxt;
   end

   // ------------------------------------------------------------------------
   // Registered AXI controls, derived from the next state so each one is a
   // flop output with no path from the mem_* inputs. AW/WVALID each drop
   // after their own handshake via the done flags.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_aw_ok   <= 1'b0;
         r_w_ok    <= 1'b0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_aw_ok   <= w_aw_ok_nxt;
         r_w_ok    <= w_w_ok_nxt;
         r_awvalid <= (w_nxt == WRITE) && !w_aw_ok_nxt;
         r_wvalid  <= (w_nxt == WRITE) && !w_w_ok_nxt;
         r_bready  <= (w_nxt == WRESP);
         r_arvalid <= (w_nxt == RADDR);
         r_rready  <= (w_nxt == RDATA);
         r_done    <= (w_nxt == RESP);
      end
   end

   // Request capture and timeout counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_addr  <= mem_addr;
         r_wdata <= mem_wdata;
         r_wstrb <= mem_wstrb;
         r_cnt   <= '0;
      end else if (w_active) begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   // Response capture; updates on the edge that enters RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= '0;
         r_resp  <= 2'b00;
      end else if (w_tmo_fire) begin
         r_resp <= 2'b11;
         // A timed-out load returns zero; a timed-out store leaves the last
         // load data untouched.
         if ((r_state == RADDR) || (r_state == RDATA)) r_rdata <= '0;
      end else if ((r_state == WRESP) && master_if.BVALID) begin
         r_resp <= master_if.BRESP;
      end else if ((r_state == RDATA) && master_if.RVALID) begin
         r_rdata <= master_if.RDATA;
         r_resp  <= master_if.RRESP;
      end
   end

   assign master_if.AWADDR  = r_addr;
   assign master_if.AWVALID = r_awvalid;
   assign master_if.WDATA   = r_wdata;
   assign master_if.WSTRB   = r_wstrb;
   assign master_if.WVALID  = r_wvalid;
   assign master_if.BREADY  = r_bready;
   assign master_if.ARADDR  = r_addr;
   assign master_if.ARVALID = r_arvalid;
   assign master_if.RREADY  = r_rready;

   assign mem_done  = r_done;
   assign mem_rdata = r_rdata;
   assign mem_resp  = r_resp;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// ----------------------------------------------------------------------------
// tb_axi4_lite_master_bridge
// Directed bench for the AXI4-Lite master bridge. A small configurable slave
// responds once per cycle at the falling edge; each test task runs one
// scenario and compares the recorded cycle numbers and values against
// hand-computed expectations. Cycle 1 is the first cycle after the edge that
// accepts the request.
// ----------------------------------------------------------------------------
module tb_axi4_lite_master_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_resp;

   always #5 clk = ~clk;

   axi4_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi();

   axi4_lite_master_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .master_if(axi)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // slave configuration
   int          cfg_aw_wait, cfg_w_wait, cfg_ar_wait;
   logic        cfg_silent, cfg_no_b;
   logic [1:0]  cfg_bresp, cfg_rresp;
   logic [31:0] cfg_rdata;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_wstrb;

   // observations
   int          cyc;
   int          aw_cnt, w_cnt, ar_cnt;
   int          aw_hs_cyc, w_hs_cyc, ar_hs_cyc, b_first, done_cyc, done_first, done_n;
   int          bad_stable, bad_early, bad_revalid, idle_bad;
   logic [31:0] done_rdata;
   logic [1:0]  done_resp;

   // slave state
   int   aw_seen, w_seen, ar_seen;
   logic aw_done, w_done, ar_done, b_pend, r_pend, b_issued, r_issued;

   task slave_idle;
      axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.ARREADY = 1'b0;
      axi.BVALID = 1'b0; axi.BRESP = 2'b00;
      axi.RVALID = 1'b0; axi.RDATA = '0; axi.RRESP = 2'b00;
   endtask

   task cfg_default;
      cfg_aw_wait = 0; cfg_w_wait = 0; cfg_ar_wait = 0;
      cfg_silent = 1'b0; cfg_no_b = 1'b0;
      cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;
   endtask

   task obs_clear;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      aw_hs_cyc = -1; w_hs_cyc = -1; ar_hs_cyc = -1; b_first = -1;
      done_cyc = -1; done_first = -1; done_n = 0;
      bad_stable = 0; bad_early = 0; bad_revalid = 0; idle_bad = 0;
      done_rdata = '0; done_resp = 2'b00;
      aw_seen = 0; w_seen = 0; ar_seen = 0;
      aw_done = 0; w_done = 0; ar_done = 0;
      b_pend = 0; r_pend = 0; b_issued = 0; r_issued = 0;
   endtask

   // Called at the falling edge of cycle 'cyc': record what the DUT shows,
   // then drive the slave's response for the same cycle.
   task slave_step;
      if (axi.AWVALID) begin
         aw_cnt++;
         if (aw_done) bad_revalid++;
         if (axi.AWADDR !== exp_addr) bad_stable++;
      end
      if (axi.WVALID) begin
         w_cnt++;
         if (w_done) bad_revalid++;
         if (axi.WDATA !== exp_wdata || axi.WSTRB !== exp_wstrb) bad_stable++;
      end
      if (axi.ARVALID) begin
         ar_cnt++;
         if (ar_done) bad_revalid++;
         if (axi.ARADDR !== exp_addr) bad_stable++;
      end
      if (axi.BREADY) begin
         if (b_first < 0) b_first = cyc;
         if (!(aw_done && w_done)) bad_early++;
      end
      if (axi.RREADY && !ar_done) bad_early++;
      if (mem_done) begin
         done_n++; done_cyc = cyc; done_rdata = mem_rdata; done_resp = mem_resp;
      end

      axi.AWREADY = axi.AWVALID && !cfg_silent && (aw_seen >= cfg_aw_wait);
      axi.WREADY  = axi.WVALID  && !cfg_silent && (w_seen  >= cfg_w_wait);
      axi.ARREADY = axi.ARVALID && !cfg_silent && (ar_seen >= cfg_ar_wait);
      if (axi.AWVALID) aw_seen++;
      if (axi.WVALID)  w_seen++;
      if (axi.ARVALID) ar_seen++;
      if (axi.AWVALID && axi.AWREADY) begin aw_done = 1; aw_hs_cyc = cyc; end
      if (axi.WVALID  && axi.WREADY)  begin w_done  = 1; w_hs_cyc  = cyc; end
      if (axi.ARVALID && axi.ARREADY) begin ar_done = 1; ar_hs_cyc = cyc; end

      axi.BVALID = b_pend;
      axi.BRESP  = b_pend ? cfg_bresp : 2'b00;
      if (b_pend && axi.BREADY) b_pend = 0;
      axi.RVALID = r_pend;
      axi.RDATA  = r_pend ? cfg_rdata : 32'h0;
      axi.RRESP  = r_pend ? cfg_rresp : 2'b00;
      if (r_pend && axi.RREADY) r_pend = 0;

      if (aw_done && w_done && !b_issued && !cfg_silent && !cfg_no_b) begin
         b_pend = 1; b_issued = 1;
      end
      if (ar_done && !r_issued && !cfg_silent) begin
         r_pend = 1; r_issued = 1;
      end
   endtask

   // One transaction; the request is removed and the mem_* inputs scrambled
   // after acceptance so any late sampling shows up as an address/data error.
   task do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                input logic [3:0] st);
      obs_clear;
      exp_addr = addr; exp_wdata = wd; exp_wstrb = st;
      @(negedge clk);
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd; mem_wstrb = st;
      @(negedge clk);
      mem_req = 1'b0; mem_addr = ~addr; mem_wdata = ~wd; mem_wstrb = ~st;
      for (int i = 1; i <= 40; i++) begin
         cyc = i;
         slave_step;
         if (done_n > 0 && cyc >= done_cyc + 2) break;
         @(negedge clk);
      end
      slave_idle;
   endtask

   task test_reset;
      slave_idle;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (mem_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", mem_done); end
      n_checks++; if (mem_rdata !== 32'h0 || mem_resp !== 2'b00) begin n_fail++; $display("FAIL rst_rdata_resp got %h/%b exp 0/00", mem_rdata, mem_resp); end
      n_checks++; if ({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY} !== 5'b0) begin n_fail++; $display("FAIL rst_valids got %b exp 00000", {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY}); end
      n_checks++; if (axi.AWADDR !== 32'h0 || axi.WDATA !== 32'h0 || axi.WSTRB !== 4'h0 || axi.ARADDR !== 32'h0) begin n_fail++; $display("FAIL rst_addr_data got %h %h %h %h exp all 0", axi.AWADDR, axi.WDATA, axi.WSTRB, axi.ARADDR); end
      rst = 1'b1;
   endtask

   task test_store_zero_wait;
      cfg_default;
      do_xfer(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
      n_checks++; if (aw_hs_cyc !== 1 || w_hs_cyc !== 1) begin n_fail++; $display("FAIL st0_hs_cyc got aw=%0d w=%0d exp 1/1", aw_hs_cyc, w_hs_cyc); end
      n_checks++; if (aw_cnt !== 1 || w_cnt !== 1) begin n_fail++; $display("FAIL st0_valid_cnt got aw=%0d w=%0d exp 1/1", aw_cnt, w_cnt); end
      n_checks++; if (bad_stable !== 0) begin n_fail++; $display("FAIL st0_addr_data got %0d bad cycles exp 0", bad_stable); end
      n_checks++; if (b_first !== 2) begin n_fail++; $display("FAIL st0_bready_cyc got %0d exp 2", b_first); end
      n_checks++; if (done_cyc !== 3 || done_n !== 1) begin n_fail++; $display("FAIL st0_done got cyc=%0d n=%0d exp 3/1", done_cyc, done_n); end
      n_checks++; if (done_resp !== 2'b00) begin n_fail++; $display("FAIL st0_resp got %b exp 00", done_resp); end
   endtask

   task test_load_wait;
      cfg_default;
      cfg_ar_wait = 3; cfg_rdata = 32'h1234_5678;
      do_xfer(1'b0, 32'h0000_2000, 32'h0, 4'h0);
      n_checks++; if (ar_cnt !== 4 || ar_hs_cyc !== 4) begin n_fail++; $display("FAIL ld_arvalid got cnt=%0d hs=%0d exp 4/4", ar_cnt, ar_hs_cyc); end
      n_checks++; if (bad_stable !== 0 || bad_early !== 0) begin n_fail++; $display("FAIL ld_stable_early got %0d/%0d exp 0/0", bad_stable, bad_early); end
      n_checks++; if (done_cyc !== 6 || done_n !== 1) begin n_fail++; $display("FAIL ld_done got cyc=%0d n=%0d exp 6/1", done_cyc, done_n); end
      n_checks++; if (done_rdata !== 32'h1234_5678 || done_resp !== 2'b00) begin n_fail++; $display("FAIL ld_rdata got %h/%b exp 12345678/00", done_rdata, done_resp); end
   endtask

   task test_store_order;
      int aw_w [3];
      int w_w [3];
      int e_aw [3];
      int e_w [3];
      int e_done [3];
      aw_w = '{2, 0, 1}; w_w = '{0, 2, 1};
      e_aw = '{3, 1, 2}; e_w = '{1, 3, 2}; e_done = '{5, 5, 4};
      for (int k = 0; k < 3; k++) begin
         cfg_default;
         cfg_aw_wait = aw_w[k]; cfg_w_wait = w_w[k];
         do_xfer(1'b1, 32'h0000_0100 + 32'(k * 4), 32'hA000_0000 + 32'(k), 4'h5);
         n_checks++; if (aw_hs_cyc !== e_aw[k] || w_hs_cyc !== e_w[k]) begin n_fail++; $display("FAIL ord%0d_hs got aw=%0d w=%0d exp %0d/%0d", k, aw_hs_cyc, w_hs_cyc, e_aw[k], e_w[k]); end
         n_checks++; if (aw_cnt !== e_aw[k] || w_cnt !== e_w[k] || bad_revalid !== 0) begin n_fail++; $display("FAIL ord%0d_valid_cnt got aw=%0d w=%0d re=%0d exp %0d/%0d/0", k, aw_cnt, w_cnt, bad_revalid, e_aw[k], e_w[k]); end
         n_checks++; if (b_first !== e_done[k] - 1 || bad_early !== 0) begin n_fail++; $display("FAIL ord%0d_bready got cyc=%0d early=%0d exp %0d/0", k, b_first, bad_early, e_done[k] - 1); end
         n_checks++; if (done_cyc !== e_done[k] || done_n !== 1) begin n_fail++; $display("FAIL ord%0d_done got cyc=%0d n=%0d exp %0d/1", k, done_cyc, done_n, e_done[k]); end
      end
   endtask

   task test_error_resp;
      cfg_default;
      cfg_bresp = 2'b10;
      do_xfer(1'b1, 32'h0000_5000, 32'h0000_00FF, 4'h1);
      n_checks++; if (done_resp !== 2'b10 || done_cyc !== 3) begin n_fail++; $display("FAIL err_bresp got %b cyc=%0d exp 10/3", done_resp, done_cyc); end
      cfg_default;
      cfg_rdata = 32'hA5A5_0F0F;
      do_xfer(1'b0, 32'h0000_5004, 32'h0, 4'h0);
      n_checks++; if (done_resp !== 2'b00 || done_rdata !== 32'hA5A5_0F0F || done_cyc !== 3) begin n_fail++; $display("FAIL err_next_load got %b %h cyc=%0d exp 00 a5a50f0f 3", done_resp, done_rdata, done_cyc); end
   endtask

   task test_timeout;
      cfg_default;
      cfg_silent = 1'b1;
      do_xfer(1'b0, 32'hFFFF_0000, 32'h0, 4'h0);
      n_checks++; if (ar_cnt !== 16 || ar_hs_cyc !== -1) begin n_fail++; $display("FAIL tmo_arvalid got cnt=%0d hs=%0d exp 16/-1", ar_cnt, ar_hs_cyc); end
      n_checks++; if (done_cyc !== 17 || done_n !== 1) begin n_fail++; $display("FAIL tmo_done got cyc=%0d n=%0d exp 17/1", done_cyc, done_n); end
      n_checks++; if (done_resp !== 2'b11 || done_rdata !== 32'h0) begin n_fail++; $display("FAIL tmo_resp got %b %h exp 11 0", done_resp, done_rdata); end
      n_checks++; if (axi.ARVALID !== 1'b0 || axi.RREADY !== 1'b0 || mem_done !== 1'b0) begin n_fail++; $display("FAIL tmo_idle got ar=%b rr=%b done=%b exp 0 0 0", axi.ARVALID, axi.RREADY, mem_done); end
   endtask

   task test_back_to_back;
      cfg_default;
      cfg_rdata = 32'h0BAD_F00D;
      obs_clear;
      exp_addr = 32'h0000_3000;
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_3000;
      @(negedge clk);
      for (int i = 1; i <= 11; i++) begin
         cyc = i;
         slave_step;
         if (mem_done) begin
            if (done_first < 0) done_first = cyc;
            ar_done = 0; ar_seen = 0; r_issued = 0;
         end
         if (cyc == 5) mem_req = 1'b0;
         @(negedge clk);
      end
      slave_idle;
      n_checks++; if (done_n !== 2 || ar_cnt !== 2) begin n_fail++; $display("FAIL b2b_count got done=%0d ar=%0d exp 2/2", done_n, ar_cnt); end
      n_checks++; if (done_first !== 3 || done_cyc !== 7) begin n_fail++; $display("FAIL b2b_interval got %0d,%0d exp 3,7", done_first, done_cyc); end
      n_checks++; if (mem_rdata !== 32'h0BAD_F00D || bad_revalid !== 0) begin n_fail++; $display("FAIL b2b_rdata got %h re=%0d exp 0badf00d/0", mem_rdata, bad_revalid); end
   endtask

   task test_reset_mid;
      cfg_default;
      cfg_no_b = 1'b1;
      obs_clear;
      exp_addr = 32'h0000_4000; exp_wdata = 32'h1122_3344; exp_wstrb = 4'h3;
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = exp_addr; mem_wdata = exp_wdata; mem_wstrb = exp_wstrb;
      @(negedge clk);
      mem_req = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         cyc = i;
         slave_step;
         if (i < 3) @(negedge clk);
      end
      n_checks++; if (axi.BREADY !== 1'b1) begin n_fail++; $display("FAIL rmid_in_wresp got bready=%b exp 1", axi.BREADY); end
      rst = 1'b0;
      slave_idle;
      #1;
      n_checks++; if ({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY, mem_done} !== 6'b0) begin n_fail++; $display("FAIL rmid_ctrl got %b exp 000000", {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY, mem_done}); end
      n_checks++; if (mem_rdata !== 32'h0 || mem_resp !== 2'b00 || axi.AWADDR !== 32'h0 || axi.WDATA !== 32'h0) begin n_fail++; $display("FAIL rmid_data got %h %b %h %h exp all 0", mem_rdata, mem_resp, axi.AWADDR, axi.WDATA); end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (axi.AWVALID || axi.WVALID || axi.ARVALID || axi.BREADY || axi.RREADY || mem_done) idle_bad++;
      end
      n_checks++; if (idle_bad !== 0) begin n_fail++; $display("FAIL rmid_stay_idle got %0d active cycles exp 0", idle_bad); end
   endtask

   initial begin
      cfg_default;
      obs_clear;
      exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
      test_reset;
      test_store_zero_wait;
      test_load_wait;
      test_store_order;
      test_error_resp;
      test_timeout;
      test_back_to_back;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1);
   end

endmodule
